// File: rtl/multicore_run_controller_pkg.sv
// multicore_pkg: shared definitions for the multicore run controller.
//   - per-core status codes driven to the processor array
//   - controller state encoding
//   - default core count
package multicore_pkg;

    localparam int DEFAULT_NUM_CORES = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_HALT = 2'b10;
    // 2'b11 is reserved and never driven.

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_RUN,
        S_DONE,
        S_TIMEOUT
    } state_e;

endpackage

// File: rtl/multicore_run_controller_if.sv
// multicore_run_controller_if: host/processor-side signal bundle of the
// run controller.
//   master : host/harness side (drives start, clear, core_mask,
//            timeout_cycles and the processor's end_process levels)
//   slave  : controller side (drives status, busy, done, timed_out,
//            finished_mask, cycle_count)
interface multicore_run_controller_if
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int STATUS_W  = 2,
    parameter int CYCLE_W   = 32
);

    logic                          start;
    logic                          clear;
    logic [NUM_CORES-1:0]          core_mask;
    logic [CYCLE_W-1:0]            timeout_cycles;
    logic [NUM_CORES-1:0]          end_process;
    logic [NUM_CORES*STATUS_W-1:0] status;
    logic                          busy;
    logic                          done;
    logic                          timed_out;
    logic [NUM_CORES-1:0]          finished_mask;
    logic [CYCLE_W-1:0]            cycle_count;

    modport master (
        output start, clear, core_mask, timeout_cycles, end_process,
        input  status, busy, done, timed_out, finished_mask, cycle_count
    );

    modport slave (
        input  start, clear, core_mask, timeout_cycles, end_process,
        output status, busy, done, timed_out, finished_mask, cycle_count
    );

endinterface

// File: rtl/multicore_run_controller_sat_counter.sv
// sat_cycle_counter: CYCLE_W-bit up counter with synchronous clear and
// enable that saturates at all-ones.
//   clock, reset : clock and asynchronous active-high reset
//   clear        : load zero (has priority over enable)
//   enable       : count up by one unless saturated
//   count        : registered count
//   count_next   : value count will take at the next edge
module sat_cycle_counter #(
    parameter int CYCLE_W = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clear,
    input  logic               enable,
    output logic [CYCLE_W-1:0] count,
    output logic [CYCLE_W-1:0] count_next
);

    logic [CYCLE_W-1:0] count_q;
    logic [CYCLE_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && (count_q != '1)) begin
            count_d = count_q + CYCLE_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign count_next = count_d;

endmodule

// File: rtl/multicore_run_controller.sv
// multicore_run_controller: launch/monitor controller for the N-core
// matrix-multiply processor.
//   clock, reset : clock and asynchronous active-high reset
//   bus (slave)  : start/clear handshake, core_mask and timeout_cycles
//                  (sampled on an accepted start), end_process levels,
//                  and the registered outputs status, busy, done,
//                  timed_out, finished_mask and cycle_count.
// Flow: IDLE -> LAUNCH (1 cycle) -> RUN -> DONE | TIMEOUT -> (clear) IDLE.
module multicore_run_controller
    import multicore_pkg::*;
#(
    parameter int NUM_CORES = DEFAULT_NUM_CORES,
    parameter int STATUS_W  = 2,
    parameter int CYCLE_W   = 32
) (
    input logic                       clock,
    input logic                       reset,
    multicore_run_controller_if.slave bus
);

    state_e                        state_q, state_d;
    logic [NUM_CORES-1:0]          mask_q, mask_d;
    logic [CYCLE_W-1:0]            timeout_q, timeout_d;
    logic [NUM_CORES*STATUS_W-1:0] status_q, status_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic                          timed_out_q, timed_out_d;
    logic [NUM_CORES-1:0]          finished_q, finished_d;

    logic                          cnt_clear;
    logic                          cnt_en;
    logic [CYCLE_W-1:0]            cnt;
    logic [CYCLE_W-1:0]            cnt_next;
    logic [NUM_CORES-1:0]          new_fin;

    sat_cycle_counter #(
        .CYCLE_W (CYCLE_W)
    ) u_cycle_counter (
        .clock      (clock),
        .reset      (reset),
        .clear      (cnt_clear),
        .enable     (cnt_en),
        .count      (cnt),
        .count_next (cnt_next)
    );

    // Masked-off cores can never contribute to completion.
    assign new_fin = bus.end_process & mask_q;

    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        timeout_d   = timeout_q;
        status_d    = status_q;
        busy_d      = busy_q;
        done_d      = done_q;
        timed_out_d = timed_out_q;
        finished_d  = finished_q;
        cnt_clear   = 1'b0;
        cnt_en      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    mask_d     = bus.core_mask;
                    timeout_d  = bus.timeout_cycles;
                    finished_d = '0;
                    cnt_clear  = 1'b1;
                    if (bus.core_mask != '0) begin
                        state_d = S_LAUNCH;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end

            S_LAUNCH: begin
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    status_d[i*STATUS_W +: STATUS_W] =
                        mask_q[i] ? STATUS_W'(ST_RUN) : STATUS_W'(ST_IDLE);
                end
                state_d = S_RUN;
            end

            S_RUN: begin
                cnt_en     = 1'b1;
                finished_d = finished_q | new_fin;
                for (int unsigned i = 0; i < NUM_CORES; i++) begin
                    if (new_fin[i]) begin
                        status_d[i*STATUS_W +: STATUS_W] = STATUS_W'(ST_HALT);
                    end
                end
                // Completion is checked first so it wins a same-cycle timeout.
                if (finished_d == mask_q) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else if ((timeout_q != '0) && (cnt_next == timeout_q)) begin
                    state_d     = S_TIMEOUT;
                    busy_d      = 1'b0;
                    timed_out_d = 1'b1;
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        if (mask_q[i]) begin
                            status_d[i*STATUS_W +: STATUS_W] = STATUS_W'(ST_HALT);
                        end
                    end
                end
            end

            S_DONE, S_TIMEOUT: begin
                // finished_mask and cycle_count are kept for the host to read.
                if (bus.clear) begin
                    state_d     = S_IDLE;
                    done_d      = 1'b0;
                    timed_out_d = 1'b0;
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        status_d[i*STATUS_W +: STATUS_W] = STATUS_W'(ST_IDLE);
                    end
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            mask_q      <= '0;
            timeout_q   <= '0;
            status_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            timed_out_q <= 1'b0;
            finished_q  <= '0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            timeout_q   <= timeout_d;
            status_q    <= status_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            timed_out_q <= timed_out_d;
            finished_q  <= finished_d;
        end
    end

    assign bus.status        = status_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.timed_out     = timed_out_q;
    assign bus.finished_mask = finished_q;
    assign bus.cycle_count   = cnt;

endmodule

// File: tb/tb_multicore_run_controller.sv
module tb_multicore_run_controller;

    logic clock;
    logic reset;

    int n_checks = 0;
    int n_fail   = 0;

    multicore_run_controller_if #(
        .NUM_CORES (4),
        .STATUS_W  (2),
        .CYCLE_W   (32)
    ) bus ();

    multicore_run_controller #(
        .NUM_CORES (4),
        .STATUS_W  (2),
        .CYCLE_W   (32)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // f[i] = RUN cycle (1-based) at which core i raises end_process and
    // keeps it high; 0 = never finishes.
    typedef struct packed {
        logic [3:0]      mask;
        logic [31:0]     tmo;
        logic [3:0][7:0] f;
        logic [3:0]      noise;
        logic            exp_done;
        logic            exp_to;
        logic [31:0]     exp_cnt;
        logic [3:0]      exp_fin;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Cores of the mask that have finished by the end of RUN cycle k.
    function automatic logic [3:0] fin_at(input logic [3:0] mask, input logic [3:0][7:0] f,
                                          input int unsigned k);
        logic [3:0] r;
        for (int i = 0; i < 4; i++) r[i] = mask[i] && (f[i] != 0) && (f[i] <= k);
        return r;
    endfunction

    function automatic logic [7:0] stat_of(input logic [3:0] mask, input logic [3:0] fin,
                                           input bit all_halt);
        logic [7:0] s;
        for (int i = 0; i < 4; i++)
            s[i*2 +: 2] = !mask[i] ? 2'b00 : (fin[i] || all_halt) ? 2'b10 : 2'b01;
        return s;
    endfunction

    task automatic do_run(input logic [3:0] mask, input logic [31:0] tmo,
                          input logic [3:0][7:0] f, input logic [3:0] noise,
                          input bit rnd_noise, input bit poke, input bit clr_start,
                          output bit o_done, output bit o_to,
                          output logic [31:0] o_cnt, output logic [3:0] o_fin);
        int unsigned c;
        int unsigned endc;
        bit          never;
        bit          is_to;
        logic [3:0]  nz;
        logic [3:0]  efin;
        logic [7:0]  est;

        // Outcome of the run from the finish times alone.
        c = 0;
        never = 0;
        for (int i = 0; i < 4; i++)
            if (mask[i]) begin
                if (f[i] == 0) never = 1;
                else if (f[i] > c) c = f[i];
            end
        if (mask == 0) begin
            is_to = 0; endc = 0;
        end else if (tmo != 0 && (never || tmo < c)) begin
            is_to = 1; endc = tmo;
        end else begin
            is_to = 0; endc = c;
        end
        efin = (mask == 0) ? 4'b0 : fin_at(mask, f, endc);
        est  = stat_of(mask, efin, is_to);

        @(negedge clock);
        bus.start          = 1'b1;
        bus.core_mask      = mask;
        bus.timeout_cycles = tmo;
        bus.end_process    = (noise & ~mask) | fin_at(mask, f, 1);
        @(negedge clock);
        bus.start = 1'b0;
        if (mask != 0) begin
            chk("launch_busy", bus.busy, 1);
            chk("launch_status", bus.status, 0);
            chk("launch_done", bus.done, 0);
            @(negedge clock);
            chk("run0_status", bus.status, stat_of(mask, 4'b0, 0));
            chk("run0_count", bus.cycle_count, 0);
            for (int unsigned k = 1; k <= endc; k++) begin
                nz = rnd_noise ? 4'($urandom) : noise;
                bus.end_process = (nz & ~mask) | fin_at(mask, f, k);
                bus.start       = poke && (k == 2);
                bus.core_mask   = (poke && (k == 2)) ? ~mask : mask;
                @(negedge clock);
                bus.start = 1'b0;
                chk("run_count", bus.cycle_count, k);
                chk("run_fin", bus.finished_mask, fin_at(mask, f, k));
                if (k < endc) begin
                    chk("run_busy", bus.busy, 1);
                    chk("run_status", bus.status, stat_of(mask, fin_at(mask, f, k), 0));
                    chk("run_done", {bus.done, bus.timed_out}, 0);
                end
            end
        end
        chk("end_busy", bus.busy, 0);
        chk("end_done", bus.done, !is_to);
        chk("end_to", bus.timed_out, is_to);
        chk("end_count", bus.cycle_count, endc);
        chk("end_fin", bus.finished_mask, efin);
        chk("end_status", bus.status, est);
        o_done = bus.done;
        o_to   = bus.timed_out;
        o_cnt  = bus.cycle_count;
        o_fin  = bus.finished_mask;

        // Terminal state holds while end_process keeps toggling.
        for (int j = 0; j < 2; j++) begin
            bus.end_process = 4'($urandom);
            @(negedge clock);
            chk("hold_count", bus.cycle_count, endc);
            chk("hold_fin", bus.finished_mask, efin);
            chk("hold_flags", {bus.busy, bus.done, bus.timed_out}, {1'b0, !is_to, is_to});
            chk("hold_status", bus.status, est);
        end

        bus.clear = 1'b1;
        bus.start = clr_start;
        @(negedge clock);
        bus.clear = 1'b0;
        bus.start = 1'b0;
        chk("clr_flags", {bus.busy, bus.done, bus.timed_out}, 0);
        chk("clr_status", bus.status, 0);
        chk("clr_count", bus.cycle_count, endc);
        chk("clr_fin", bus.finished_mask, efin);
        @(negedge clock);
        chk("no_relaunch", {bus.busy, bus.done}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          od, ot;
        logic [31:0] oc;
        logic [3:0]  ofn;
        logic [3:0]  m;
        logic [31:0] tmo;
        logic [3:0][7:0] f;

        //               mask     tmo     f3,f2,f1,f0                       noise    done  to    cnt     fin
        vecs[0] = '{4'b1111, 32'd0,  {8'd12, 8'd8, 8'd8, 8'd5},  4'b0000, 1'b1, 1'b0, 32'd12, 4'b1111};
        vecs[1] = '{4'b0101, 32'd0,  {8'd0,  8'd3, 8'd0, 8'd3},  4'b1010, 1'b1, 1'b0, 32'd3,  4'b0101};
        vecs[2] = '{4'b0011, 32'd10, {8'd0,  8'd0, 8'd0, 8'd4},  4'b0000, 1'b0, 1'b1, 32'd10, 4'b0001};
        vecs[3] = '{4'b0011, 32'd7,  {8'd0,  8'd0, 8'd7, 8'd2},  4'b1100, 1'b1, 1'b0, 32'd7,  4'b0011};
        vecs[4] = '{4'b0000, 32'd5,  {8'd1,  8'd1, 8'd1, 8'd1},  4'b1111, 1'b1, 1'b0, 32'd0,  4'b0000};
        vecs[5] = '{4'b1000, 32'd1,  {8'd0,  8'd0, 8'd0, 8'd0},  4'b0111, 1'b0, 1'b1, 32'd1,  4'b0000};
        vecs[6] = '{4'b0110, 32'd5,  {8'd0,  8'd1, 8'd1, 8'd0},  4'b1001, 1'b1, 1'b0, 32'd1,  4'b0110};
        vecs[7] = '{4'b1111, 32'd20, {8'd4,  8'd3, 8'd2, 8'd1},  4'b0000, 1'b1, 1'b0, 32'd4,  4'b1111};

        reset              = 1'b1;
        bus.start          = 1'b0;
        bus.clear          = 1'b0;
        bus.core_mask      = '0;
        bus.timeout_cycles = '0;
        bus.end_process    = '0;
        #12;
        chk("rst_status", bus.status, 0);
        chk("rst_flags", {bus.busy, bus.done, bus.timed_out}, 0);
        chk("rst_fin", bus.finished_mask, 0);
        chk("rst_count", bus.cycle_count, 0);
        @(negedge clock);
        reset = 1'b0;
        // clear in IDLE has no effect
        bus.clear = 1'b1;
        @(negedge clock);
        bus.clear = 1'b0;
        chk("idle_clear", {bus.busy, bus.done, bus.timed_out}, 0);

        for (int t = 0; t < NV; t++) begin
            do_run(vecs[t].mask, vecs[t].tmo, vecs[t].f, vecs[t].noise,
                   1'b0, (t == 0), (t == 1 || t == 4), od, ot, oc, ofn);
            chk($sformatf("vec%0d_done", t), od, vecs[t].exp_done);
            chk($sformatf("vec%0d_to", t), ot, vecs[t].exp_to);
            chk($sformatf("vec%0d_count", t), oc, vecs[t].exp_cnt);
            chk($sformatf("vec%0d_fin", t), ofn, vecs[t].exp_fin);
        end

        // Asynchronous reset in the middle of a run.
        @(negedge clock);
        bus.start          = 1'b1;
        bus.core_mask      = 4'b1111;
        bus.timeout_cycles = '0;
        bus.end_process    = 4'b0000;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        bus.end_process = 4'b0001;
        repeat (3) @(negedge clock);
        chk("prerst_fin", bus.finished_mask, 4'b0001);
        chk("prerst_count", bus.cycle_count, 3);
        #2 reset = 1'b1;
        #1;
        chk("arst_status", bus.status, 0);
        chk("arst_busy", bus.busy, 0);
        chk("arst_fin", bus.finished_mask, 0);
        chk("arst_count", bus.cycle_count, 0);
        @(negedge clock);
        reset = 1'b0;
        bus.end_process = '0;
        @(negedge clock);
        chk("postrst_idle", {bus.busy, bus.done, bus.status}, 0);
        do_run(vecs[0].mask, vecs[0].tmo, vecs[0].f, vecs[0].noise, 1'b0, 1'b0, 1'b0, od, ot, oc, ofn);
        chk("rerun_count", oc, 32'd12);
        chk("rerun_fin", ofn, 4'b1111);

        for (int r = 0; r < 30; r++) begin
            m = 4'($urandom);
            if (r % 7 == 0) m = 4'b0000;
            for (int i = 0; i < 4; i++) f[i] = 8'($urandom_range(0, 15));
            tmo = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(1, 20));
            if (tmo == 0)
                for (int i = 0; i < 4; i++)
                    if (m[i] && f[i] == 0) f[i] = 8'($urandom_range(1, 15));
            do_run(m, tmo, f, 4'($urandom), 1'b1, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), od, ot, oc, ofn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
